// File: rtl/ecc_enc_pipe.sv
// Two-stage SEC check-bit generator feeding the 32-bit single-error corrector.
// Optional error injection is compiled in with `define ECC_ERR_INJECT_EN.

module ecc_par_lane #(
  parameter logic [31:0] MASK = '0
) (
  input  logic [31:0] data,
  output logic        par
);
  assign par = ^(data & MASK);
endmodule

module ecc_enc_pipe #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [7:0]       out_check,
  output logic             out_en,
  output logic [CNT_W-1:0] word_cnt
`ifdef ECC_ERR_INJECT_EN
  ,
  input  logic             inj_req,
  input  logic [5:0]       inj_bit
`endif
);
  localparam int STAGES = 2;
  localparam int NUM_CHK = 8;

  // Codeword bit numbering: 0..31 data, 32+k check bit k.
  typedef struct packed {
    logic [7:0]  check;
    logic [31:0] data;
  } cw_t;

  localparam logic [NUM_CHK-1:0][31:0] PAR_MASK = {
    32'h8888F0F0, 32'h44440F0F, 32'h2222FF00, 32'h111100FF,
    32'hF0F08888, 32'h0F0F4444, 32'hFF002222, 32'h00FF1111
  };

  logic [STAGES:1] vld_pipe;
  logic [31:0]     s1_data;
  cw_t             s2_cw;
  cw_t             s2_nxt;
  logic [NUM_CHK-1:0] chk_gen;
  logic [39:0]     flip;
  logic            accept;
  logic            s2_load;
  logic            release_w;

  genvar k;
  generate
    for (k = 0; k < NUM_CHK; k++) begin : g_lane
      ecc_par_lane #(.MASK(PAR_MASK[k])) u_lane (
        .data (s1_data),
        .par  (chk_gen[k])
      );
    end
  endgenerate

  assign release_w = vld_pipe[2] & out_ready;
  assign s2_load   = vld_pipe[1] & (~vld_pipe[2] | out_ready);
  assign in_ready  = ~vld_pipe[1] | s2_load;
  assign accept    = in_valid & in_ready;

`ifdef ECC_ERR_INJECT_EN
  logic       inj_arm;
  logic [5:0] inj_sel;

  // One-shot: arms on request, fires on the next S2 load, requests while armed are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inj_arm <= 1'b0;
      inj_sel <= '0;
    end else if (inj_arm) begin
      if (s2_load) inj_arm <= 1'b0;
    end else if (inj_req) begin
      inj_arm <= 1'b1;
      inj_sel <= inj_bit;
    end
  end

  always_comb begin
    flip = '0;
    if (inj_arm && inj_sel < 6'd40) flip = 40'd1 << inj_sel;
  end
`else
  assign flip = '0;
`endif

  assign s2_nxt = cw_t'({chk_gen, s1_data} ^ flip);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_data  <= '0;
      s2_cw    <= '0;
      word_cnt <= '0;
    end else begin
      if (accept) begin
        vld_pipe[1] <= 1'b1;
        s1_data     <= in_data;
      end else if (s2_load) begin
        vld_pipe[1] <= 1'b0;
      end
      if (s2_load) begin
        vld_pipe[2] <= 1'b1;
        s2_cw       <= s2_nxt;
      end else if (release_w) begin
        vld_pipe[2] <= 1'b0;
      end
      if (release_w) word_cnt <= word_cnt + 1'b1;
    end
  end

  assign out_valid = vld_pipe[2];
  assign out_en    = vld_pipe[2];
  assign out_data  = s2_cw.data;
  assign out_check = s2_cw.check;
endmodule
